// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the parametrised FIR filter.
//   acc_w()            accumulator width for a given sample/coef width and tap count
//   addr_w()           coefficient-address width for a given tap count
//   sat_max()/sat_min() two's-complement limits of a DW-bit signed value
//   sample_t/coef_t/acc_t  types for the default build (11 taps, 16-bit data/coef)
package fir_pkg;

   localparam int DEF_NTAPS     = 11;
   localparam int DEF_DW        = 16;
   localparam int DEF_CW        = 16;
   localparam int DEF_OUT_SHIFT = 15;

   function automatic int acc_w(input int dw, input int cw, input int ntaps);
      return dw + cw + $clog2(ntaps);
   endfunction

   function automatic int addr_w(input int ntaps);
      return (ntaps > 1) ? $clog2(ntaps) : 1;
   endfunction

   function automatic longint sat_max(input int dw);
      return (longint'(1) <<< (dw - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int dw);
      return -(longint'(1) <<< (dw - 1));
   endfunction

   typedef logic signed [DEF_DW-1:0]                              sample_t;
   typedef logic signed [DEF_CW-1:0]                              coef_t;
   typedef logic signed [acc_w(DEF_DW, DEF_CW, DEF_NTAPS)-1:0]    acc_t;

endpackage

// File: rtl/fir_param_if.sv
// fir_param_if: sample stream and coefficient write port of fir_param.
//   DIN/VIN                 input sample and its valid strobe
//   COEF_WE/ADDR/DATA       coefficient write port, h[ADDR] <= DATA
//   DOUT/VOUT               filtered sample and its 1-cycle valid pulse
// Modports: master = source/consumer side, slave = filter side.
interface fir_param_if
   import fir_pkg::*;
#(
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int NTAPS = 11
);
   logic signed [DW-1:0]            DIN;
   logic                            VIN;
   logic                            COEF_WE;
   logic [addr_w(NTAPS)-1:0]        COEF_ADDR;
   logic signed [CW-1:0]            COEF_DATA;
   logic signed [DW-1:0]            DOUT;
   logic                            VOUT;

   modport master (
      output DIN, VIN, COEF_WE, COEF_ADDR, COEF_DATA,
      input  DOUT, VOUT
   );

   modport slave (
      input  DIN, VIN, COEF_WE, COEF_ADDR, COEF_DATA,
      output DOUT, VOUT
   );
endinterface

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational output stage of fir_param.
//   i_acc   signed accumulator (ACC_W bits)
//   o_dout  (i_acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, reduced to DW bits
// Macro FIR_SAT_EN: defined -> clamp to the DW-bit signed range;
//                   undefined -> keep the low DW bits (two's-complement wrap).
module fir_round_sat
   import fir_pkg::*;
#(
   parameter int ACC_W     = 36,
   parameter int DW        = 16,
   parameter int OUT_SHIFT = 15
) (
   input  logic signed [ACC_W-1:0] i_acc,
   output logic signed [DW-1:0]    o_dout
);
   // One guard bit so adding the rounding constant can never wrap.
   localparam int RW = ACC_W + 1;
   localparam logic signed [RW-1:0] C_HALF = RW'(1) << (OUT_SHIFT - 1);

   logic signed [RW-1:0] w_biased;
   logic signed [RW-1:0] w_shifted;

   assign w_biased  = {i_acc[ACC_W-1], i_acc} + C_HALF;
   assign w_shifted = w_biased >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
   localparam logic signed [RW-1:0] C_MAX = RW'(sat_max(DW));
   localparam logic signed [RW-1:0] C_MIN = RW'(sat_min(DW));

   always_comb begin
      o_dout = w_shifted[DW-1:0];
      if (w_shifted > C_MAX)
         o_dout = C_MAX[DW-1:0];
      else if (w_shifted < C_MIN)
         o_dout = C_MIN[DW-1:0];
   end
`else
   logic w_unused_hi;

   assign o_dout      = w_shifted[DW-1:0];
   assign w_unused_hi = ^w_shifted[RW-1:DW];
`endif

endmodule

// File: rtl/fir_param.sv
// fir_param: parametrised direct-form FIR, y[n] = sum h[k]*x[n-k].
//   CLK    clock, rising edge
//   RST_n  synchronous active-low reset (clears delay line, coefficients, pipe)
//   bus    fir_param_if.slave: DIN/VIN in, COEF_WE/ADDR/DATA in, DOUT/VOUT out
// Pipeline: S1 delay-line shift + products, S2 sum, S3 round/saturate.
// Macro FIR_SAT_EN selects output saturation (see fir_round_sat).
module fir_param
   import fir_pkg::*;
#(
   parameter int NTAPS     = 11,
   parameter int DW        = 16,
   parameter int CW        = 16,
   parameter int OUT_SHIFT = 15
) (
   input  logic      CLK,
   input  logic      RST_n,
   fir_param_if.slave bus
);
   localparam int PW    = DW + CW;
   localparam int ACC_W = acc_w(DW, CW, NTAPS);

   logic signed [DW-1:0]    r_x    [0:NTAPS-2];  // x[n-1] .. x[n-(NTAPS-1)]
   logic signed [CW-1:0]    r_h    [0:NTAPS-1];
   logic signed [PW-1:0]    r_prod [0:NTAPS-1];
   logic signed [DW-1:0]    w_xn   [0:NTAPS-1];  // window including the incoming sample
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [DW-1:0]    w_round;
   logic signed [DW-1:0]    r_dout;
   logic                    r_v1;
   logic                    r_v2;
   logic                    r_vout;

   always_comb begin
      w_xn    = '{default: '0};
      w_xn[0] = bus.DIN;
      for (int unsigned k = 1; k < NTAPS; k++)
         w_xn[k] = r_x[k-1];
   end

   // S1: coefficient bank, delay line and products. Products read r_h before
   // this edge's write lands, so a write coinciding with VIN uses the old value.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         for (int unsigned k = 0; k < NTAPS - 1; k++) r_x[k] <= '0;
         for (int unsigned k = 0; k < NTAPS; k++) begin
            r_h[k]    <= '0;
            r_prod[k] <= '0;
         end
         r_v1 <= 1'b0;
      end else begin
         if (bus.COEF_WE && (int'(bus.COEF_ADDR) < NTAPS))
            r_h[bus.COEF_ADDR] <= bus.COEF_DATA;
         if (bus.VIN) begin
            for (int unsigned k = 0; k < NTAPS - 1; k++) r_x[k] <= w_xn[k];
            for (int unsigned k = 0; k < NTAPS; k++)
               r_prod[k] <= PW'(w_xn[k]) * PW'(r_h[k]);
         end
         r_v1 <= bus.VIN;
      end
   end

   always_comb begin
      w_sum = '0;
      for (int unsigned k = 0; k < NTAPS; k++)
         w_sum = w_sum + ACC_W'(r_prod[k]);
   end

   // S2: registered sum.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_acc <= '0;
         r_v2  <= 1'b0;
      end else begin
         r_acc <= w_sum;
         r_v2  <= r_v1;
      end
   end

   fir_round_sat #(
      .ACC_W    (ACC_W),
      .DW       (DW),
      .OUT_SHIFT(OUT_SHIFT)
   ) u_round_sat (
      .i_acc (r_acc),
      .o_dout(w_round)
   );

   // S3: DOUT only moves on a valid result and holds otherwise.
   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         r_dout <= '0;
         r_vout <= 1'b0;
      end else begin
         if (r_v2) r_dout <= w_round;
         r_vout <= r_v2;
      end
   end

   assign bus.DOUT = r_dout;
   assign bus.VOUT = r_vout;

endmodule

// File: tb/tb_fir_param.sv
module tb_fir_param;
   import fir_pkg::*;

   localparam int NT = DEF_NTAPS;
   localparam int AW = addr_w(NT);

   logic CLK   = 1'b0;
   logic RST_n = 1'b0;

   fir_param_if #(.DW(DEF_DW), .CW(DEF_CW), .NTAPS(NT)) bus ();

   fir_param #(
      .NTAPS    (NT),
      .DW       (DEF_DW),
      .CW       (DEF_CW),
      .OUT_SHIFT(DEF_OUT_SHIFT)
   ) dut (
      .CLK  (CLK),
      .RST_n(RST_n),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: sample history (newest first), coefficient array and a
   // queue of expected outputs tagged with the cycle they become visible.
   typedef struct {
      int      due;
      sample_t val;
   } exp_t;

   exp_t    exp_q[$];
   longint  hist[$];
   longint  h_m[NT];
   int      cyc;
   sample_t last_dout;
   sample_t exp_dout;
   logic    exp_vout;
   int      n_chk;
   int      n_pass;

   function automatic sample_t model_y();
      longint acc;
      longint r;
      acc = 0;
      for (int k = 0; k < hist.size(); k++) acc += h_m[k] * hist[k];
      r = (acc + (longint'(1) <<< (DEF_OUT_SHIFT - 1))) >>> DEF_OUT_SHIFT;
`ifdef FIR_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      return sample_t'(r);
   endfunction

   task automatic tick(input sample_t din, input logic vin, input logic we,
                       input logic [AW-1:0] addr, input coef_t cdata, input logic rstn);
      exp_t e;
      bus.DIN = din; bus.VIN = vin; bus.COEF_WE = we;
      bus.COEF_ADDR = addr; bus.COEF_DATA = cdata; RST_n = rstn;
      @(posedge CLK);
      cyc++;
      if (!rstn) begin
         hist.delete();
         exp_q.delete();
         foreach (h_m[k]) h_m[k] = 0;
         last_dout = '0;
      end else begin
         if (vin) begin
            hist.push_front(longint'(din));
            if (hist.size() > NT) void'(hist.pop_back());
            e.due = cyc + 2;
            e.val = model_y();
            exp_q.push_back(e);
         end
         if (we && int'(addr) < NT) h_m[addr] = longint'(cdata);
      end
      #1;
      exp_vout = 1'b0;
      exp_dout = last_dout;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         exp_vout  = 1'b1;
         exp_dout  = exp_q[0].val;
         last_dout = exp_q[0].val;
         void'(exp_q.pop_front());
      end
   endtask

   task automatic load_coefs(input int mode);  // 0: 1000*(k+1), 1: all 0x7FFF
      for (int k = 0; k < NT; k++) begin
         tick('0, 1'b0, 1'b1, AW'(k), (mode == 0) ? coef_t'(1000 * (k + 1)) : 16'sh7FFF, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL load cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
      end
   endtask

   task automatic flush();
      for (int i = 0; i < NT + 3; i++) begin
         tick('0, i < NT, 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL flush cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      int first;
      for (int i = 0; i < 6; i++) begin
         tick(sample_t'($urandom), i[0], 1'b1, AW'($urandom_range(0, NT - 1)), coef_t'($urandom), 1'b0);
         n_chk++;
         if (bus.VOUT !== 1'b0 || bus.DOUT !== 16'sd0)
            $display("FAIL reset_hold cyc=%0d VOUT=%b exp 0 DOUT=%0d exp 0", cyc, bus.VOUT, bus.DOUT);
         else n_pass++;
      end
      first = -1;
      for (int i = 0; i < 8; i++) begin
         tick(sample_t'($urandom), i == 3, 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL reset_release cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
         if (bus.VOUT === 1'b1 && first < 0) first = i;
      end
      n_chk++;
      if (first != 5) $display("FAIL reset_first_vout tick=%0d exp 5", first);
      else n_pass++;
   endtask

   task automatic test_impulse();
      int      idx;
      sample_t lit;
      load_coefs(0);
      flush();
      idx = 0;
      for (int i = 0; i < 15; i++) begin
         tick((i == 0) ? 16'sd16384 : 16'sd0, i < 12, 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL impulse cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
         if (bus.VOUT === 1'b1) begin
            lit = (idx < 11) ? sample_t'(500 * (idx + 1)) : '0;
            n_chk++;
            if (bus.DOUT !== lit || i != idx + 2)
               $display("FAIL impulse_val out=%0d tick=%0d DOUT=%0d exp %0d at tick %0d", idx, i, bus.DOUT, lit, idx + 2);
            else n_pass++;
            idx++;
         end
      end
      n_chk++;
      if (idx != 12) $display("FAIL impulse_count got %0d exp 12", idx);
      else n_pass++;
   endtask

   task automatic test_gapped();
      int      idx;
      sample_t lit;
      flush();
      idx = 0;
      for (int i = 0; i < 27; i++) begin
         tick((i == 0) ? 16'sd16384 : 16'sd0, (i % 2 == 0) && (i < 24), 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL gapped cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
         if (bus.VOUT === 1'b1) begin
            lit = (idx < 11) ? sample_t'(500 * (idx + 1)) : '0;
            n_chk++;
            if (bus.DOUT !== lit || i != 2 * idx + 2)
               $display("FAIL gapped_val out=%0d tick=%0d DOUT=%0d exp %0d at tick %0d", idx, i, bus.DOUT, lit, 2 * idx + 2);
            else n_pass++;
            idx++;
         end
      end
      n_chk++;
      if (idx != 12) $display("FAIL gapped_count got %0d exp 12", idx);
      else n_pass++;
   endtask

   task automatic test_coef_race();
      int      idx;
      sample_t first_v;
      sample_t second_v;
      sample_t lit;
      load_coefs(0);
      flush();
      for (int r = 0; r < 3; r++) begin
         if (r == 2) begin
            tick('0, 1'b0, 1'b1, AW'(12), 16'sh4000, 1'b1);
            n_chk++;
            if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
               $display("FAIL race_oob cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
            else n_pass++;
         end
         idx = 0; first_v = 'x; second_v = 'x;
         for (int i = 0; i < 14; i++) begin
            tick((i == 0) ? 16'sd16384 : 16'sd0, i < 11, (r == 0) && (i == 0), '0, '0, 1'b1);
            n_chk++;
            if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
               $display("FAIL race cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
            else n_pass++;
            if (bus.VOUT === 1'b1) begin
               if (idx == 0) first_v = bus.DOUT;
               if (idx == 1) second_v = bus.DOUT;
               idx++;
            end
         end
         lit = (r == 0) ? 16'sd500 : 16'sd0;
         n_chk++;
         if (first_v !== lit || second_v !== 16'sd1000)
            $display("FAIL race_first round=%0d first=%0d exp %0d second=%0d exp 1000", r, first_v, lit, second_v);
         else n_pass++;
      end
   endtask

   task automatic test_overflow();
      int      idx;
      sample_t lit;
`ifdef FIR_SAT_EN
      lit = 16'sh7FFF;
`else
      lit = 16'sh7FEA;
`endif
      load_coefs(1);
      flush();
      idx = 0;
      for (int i = 0; i < 14; i++) begin
         tick(16'sh7FFF, i < 11, 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL overflow cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
         if (bus.VOUT === 1'b1) begin
            if (idx == 10) begin
               n_chk++;
               if (bus.DOUT !== lit) $display("FAIL overflow_11th DOUT=%h exp %h", bus.DOUT, lit);
               else n_pass++;
            end
            idx++;
         end
      end
   endtask

   task automatic test_random();
      logic we;
      for (int i = 0; i < 300; i++) begin
         we = ($urandom_range(0, 7) == 0);
         tick(sample_t'($urandom), $urandom_range(0, 2) != 0, we,
              AW'($urandom_range(0, 15)), coef_t'($urandom), 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL random cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
      end
   endtask

   task automatic test_midreset();
      int nv;
      load_coefs(0);
      flush();
      for (int i = 0; i < 6; i++) begin
         tick((i == 0) ? 16'sd16384 : 16'sd1000, 1'b1, 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== exp_dout)
            $display("FAIL midreset_pre cyc=%0d VOUT=%b exp %b DOUT=%0d exp %0d", cyc, bus.VOUT, exp_vout, bus.DOUT, exp_dout);
         else n_pass++;
      end
      tick(16'sd1000, 1'b1, 1'b0, '0, '0, 1'b0);
      nv = 0;
      for (int i = 0; i < 18; i++) begin
         tick((i == 3) ? 16'sd16384 : 16'sd0, (i >= 3) && (i < 15), 1'b0, '0, '0, 1'b1);
         n_chk++;
         if (bus.VOUT !== exp_vout || bus.DOUT !== 16'sd0)
            $display("FAIL midreset_post cyc=%0d VOUT=%b exp %b DOUT=%0d exp 0", cyc, bus.VOUT, exp_vout, bus.DOUT);
         else n_pass++;
         if (bus.VOUT === 1'b1) nv++;
      end
      n_chk++;
      if (nv != 12) $display("FAIL midreset_count got %0d exp 12", nv);
      else n_pass++;
   endtask

   initial begin
      cyc = 0; n_chk = 0; n_pass = 0; last_dout = '0;
      foreach (h_m[k]) h_m[k] = 0;
      bus.DIN = '0; bus.VIN = 1'b0; bus.COEF_WE = 1'b0; bus.COEF_ADDR = '0; bus.COEF_DATA = '0;
      test_reset();
      test_impulse();
      test_gapped();
      test_coef_race();
      test_overflow();
      test_random();
      test_midreset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

endmodule
